// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control sequencer: state encoding,
// button event priority and default timing constants.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2,
      ST_VIEW = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      EV_NONE  = 2'd0,
      EV_START = 2'd1,
      EV_LAP   = 2'd2,
      EV_VIEW  = 2'd3
   } event_e;

   localparam int DEF_TICK_DIV   = 500000;
   localparam int DEF_DEB_CYCLES = 50000;

   // Start beats lap beats view; losers in the same cycle are simply dropped.
   function automatic event_e pick_event(input logic start, input logic lap, input logic view);
      if (start)     return EV_START;
      else if (lap)  return EV_LAP;
      else if (view) return EV_VIEW;
      else           return EV_NONE;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low button -> 2-flop synchronizer -> stability counter ->
// single-cycle press pulse on the accepted released-to-pressed edge.
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_ni,
   output logic press_o
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic          sync1_q, sync2_q, acc_q, press_q;
   logic [CW-1:0] cnt_q;
   logic          accept;

   // The level flips on the DEB_CYCLES-th consecutive differing sample.
   assign accept  = (sync2_q != acc_q) && (cnt_q == CW'(DEB_CYCLES - 1));
   assign press_o = press_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         acc_q   <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_ni;
         sync2_q <= sync1_q;
         press_q <= accept && !sync2_q;
         if (sync2_q == acc_q) begin
            cnt_q <= '0;
         end else if (accept) begin
            acc_q <= sync2_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/stop/clear sequencer for the stopwatch datapath: debounced buttons in,
// tick, clear, lap write strobes and display slot selection out.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int LAPS       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start_n,
   input  logic       btn_lap_n,
   input  logic       btn_view_n,
   output logic       run,
   output logic       tick,
   output logic       clear,
   output logic       lap_we,
   output logic [2:0] lap_idx,
   output logic [2:0] view_idx,
   output logic [1:0] state
);

   localparam int PW = $clog2(TICK_DIV);

   logic   ev_start, ev_lap, ev_view;
   event_e ev;

   state_e        state_q, state_d, ret_q, ret_d;
   logic [2:0]    lap_cnt_q, lap_cnt_d, lap_idx_q, lap_idx_d, view_idx_q, view_idx_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          run_q, run_d, tick_q, tick_d, clear_q, clear_d, lap_we_q, lap_we_d;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
      .clk_i(clk), .rst_ni(reset), .btn_ni(btn_start_n), .press_o(ev_start));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
      .clk_i(clk), .rst_ni(reset), .btn_ni(btn_lap_n), .press_o(ev_lap));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_view (
      .clk_i(clk), .rst_ni(reset), .btn_ni(btn_view_n), .press_o(ev_view));

   assign ev = pick_event(ev_start, ev_lap, ev_view);

   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      lap_cnt_d  = lap_cnt_q;
      lap_idx_d  = lap_idx_q;
      view_idx_d = view_idx_q;
      presc_d    = presc_q;
      clear_d    = 1'b0;
      lap_we_d   = 1'b0;

      if (state_q == ST_RUN)
         presc_d = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + PW'(1);

      unique case (state_q)
         ST_IDLE: begin
            if (ev == EV_START) begin
               state_d = ST_RUN;
            end else if (ev == EV_VIEW && lap_cnt_q != 3'd0) begin
               state_d    = ST_VIEW;
               ret_d      = ST_IDLE;
               view_idx_d = 3'd1;
            end
         end
         ST_RUN: begin
            if (ev == EV_START) begin
               state_d = ST_STOP;
            end else if (ev == EV_LAP && lap_cnt_q < 3'(LAPS)) begin
               lap_we_d  = 1'b1;
               lap_idx_d = lap_cnt_q + 3'd1;
               lap_cnt_d = lap_cnt_q + 3'd1;
            end
         end
         ST_STOP: begin
            if (ev == EV_START) begin
               state_d = ST_RUN;
            end else if (ev == EV_LAP) begin
               state_d    = ST_IDLE;
               clear_d    = 1'b1;
               lap_cnt_d  = 3'd0;
               view_idx_d = 3'd0;
               presc_d    = '0;
            end else if (ev == EV_VIEW && lap_cnt_q != 3'd0) begin
               state_d    = ST_VIEW;
               ret_d      = ST_STOP;
               view_idx_d = 3'd1;
            end
         end
         ST_VIEW: begin
            // Stepping past the last stored lap returns to where viewing began.
            if (ev == EV_VIEW) begin
               if (view_idx_q < lap_cnt_q) begin
                  view_idx_d = view_idx_q + 3'd1;
               end else begin
                  view_idx_d = 3'd0;
                  state_d    = ret_q;
               end
            end else if (ev == EV_LAP) begin
               view_idx_d = 3'd0;
               state_d    = ret_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      run_d  = (state_d == ST_RUN);
      tick_d = (state_d == ST_RUN) && (presc_d == PW'(TICK_DIV - 1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ret_q      <= ST_IDLE;
         lap_cnt_q  <= 3'd0;
         lap_idx_q  <= 3'd0;
         view_idx_q <= 3'd0;
         presc_q    <= '0;
         run_q      <= 1'b0;
         tick_q     <= 1'b0;
         clear_q    <= 1'b0;
         lap_we_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ret_q      <= ret_d;
         lap_cnt_q  <= lap_cnt_d;
         lap_idx_q  <= lap_idx_d;
         view_idx_q <= view_idx_d;
         presc_q    <= presc_d;
         run_q      <= run_d;
         tick_q     <= tick_d;
         clear_q    <= clear_d;
         lap_we_q   <= lap_we_d;
      end
   end

   assign run      = run_q;
   assign tick     = tick_q;
   assign clear    = clear_q;
   assign lap_we   = lap_we_q;
   assign lap_idx  = lap_idx_q;
   assign view_idx = view_idx_q;
   assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios then random button activity,
// all checked every cycle against a behavioural model of the stopwatch.
module tb_stopwatch_ctrl;

   localparam int TD  = 4;
   localparam int DEB = 3;
   localparam int NL  = 4;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] raw_n = 3'b111;   // bit0 start, bit1 lap, bit2 view

   logic       run, tick, clear, lap_we;
   logic [2:0] lap_idx, view_idx;
   logic [1:0] state;

   stopwatch_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DEB), .LAPS(NL)) dut (
      .clk(clk), .reset(reset),
      .btn_start_n(raw_n[0]), .btn_lap_n(raw_n[1]), .btn_view_n(raw_n[2]),
      .run(run), .tick(tick), .clear(clear), .lap_we(lap_we),
      .lap_idx(lap_idx), .view_idx(view_idx), .state(state));

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Behavioural model: mode 0 idle, 1 running, 2 stopped, 3 viewing.
   int        m_mode, m_back, m_laps, m_lap_idx, m_view, m_phase;
   bit        m_tick, m_clear, m_lap_we;
   bit [15:0] hist [3];
   bit        m_acc [3];
   bit        m_ev  [3];
   int        cnt_lapwe, cnt_clear, cnt_tick;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_back = 0; m_laps = 0; m_lap_idx = 0; m_view = 0; m_phase = 0;
      m_tick = 0; m_clear = 0; m_lap_we = 0;
      for (int b = 0; b < 3; b++) begin
         hist[b]  = '1;
         m_acc[b] = 1'b1;
         m_ev[b]  = 1'b0;
      end
   endtask

   task automatic model_edge();
      int  ev;
      bit  same;
      ev = m_ev[0] ? 1 : m_ev[1] ? 2 : m_ev[2] ? 3 : 0;
      m_clear = 0; m_lap_we = 0;
      if (m_mode == 1) m_phase = (m_phase + 1) % TD;
      case (m_mode)
         0: if (ev == 1) m_mode = 1;
            else if (ev == 3 && m_laps > 0) begin m_back = 0; m_mode = 3; m_view = 1; end
         1: if (ev == 1) m_mode = 2;
            else if (ev == 2 && m_laps < NL) begin m_laps++; m_lap_we = 1; m_lap_idx = m_laps; end
         2: if (ev == 1) m_mode = 1;
            else if (ev == 2) begin m_clear = 1; m_laps = 0; m_view = 0; m_phase = 0; m_mode = 0; end
            else if (ev == 3 && m_laps > 0) begin m_back = 2; m_mode = 3; m_view = 1; end
         default: if (ev == 3) begin
                     if (m_view < m_laps) m_view++;
                     else begin m_view = 0; m_mode = m_back; end
                  end else if (ev == 2) begin m_view = 0; m_mode = m_back; end
      endcase
      m_tick = (m_mode == 1) && (m_phase == TD - 1);
      // Button accepted when the last DEB synchronised samples agree and differ.
      for (int b = 0; b < 3; b++) begin
         hist[b] = {hist[b][14:0], raw_n[b]};
         m_ev[b] = 1'b0;
         same = 1'b1;
         for (int i = 2; i <= DEB + 1; i++)
            if (hist[b][i] != hist[b][2]) same = 1'b0;
         if (same && hist[b][2] != m_acc[b]) begin
            m_acc[b] = hist[b][2];
            m_ev[b]  = (hist[b][2] == 1'b0);
         end
      end
   endtask

   task automatic check_all();
      chk("state",    8'(state),    8'(m_mode));
      chk("run",      8'(run),      8'(m_mode == 1));
      chk("tick",     8'(tick),     8'(m_tick));
      chk("clear",    8'(clear),    8'(m_clear));
      chk("lap_we",   8'(lap_we),   8'(m_lap_we));
      chk("lap_idx",  8'(lap_idx),  8'(m_lap_idx));
      chk("view_idx", 8'(view_idx), 8'(m_view));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
      if (lap_we === 1'b1) cnt_lapwe++;
      if (clear === 1'b1)  cnt_clear++;
      if (tick === 1'b1)   cnt_tick++;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic press(input logic [2:0] mask, input int hold);
      raw_n = raw_n & ~mask;
      steps(hold);
      raw_n = raw_n | mask;
      steps(DEB + 4);
   endtask

   initial begin
      int c0;
      model_reset();
      cnt_lapwe = 0; cnt_clear = 0; cnt_tick = 0;
      repeat (3) @(negedge clk);
      check_all();
      reset = 1'b1;

      // 1: start press -> run on the 6th cycle, then ticks every TD cycles
      raw_n[0] = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("t1_run_latency", 8'(run), 8'(i == 6));
      end
      steps(4);
      raw_n[0] = 1'b1;
      c0 = cnt_tick;
      steps(16);
      chk("t1_tick_count", 8'(cnt_tick - c0), 8'd4);
      chk("t1_state_run", 8'(state), 8'd1);

      // 2: five clean lap presses -> four strobes, slots 1..4
      c0 = cnt_lapwe;
      for (int i = 0; i < 5; i++) press(3'b010, DEB + 4);
      chk("t2_lap_strobes", 8'(cnt_lapwe - c0), 8'd4);
      chk("t2_lap_idx_last", 8'(lap_idx), 8'd4);

      // 3: start+lap together -> stop, no strobe; resume and stop again
      c0 = cnt_lapwe;
      press(3'b011, DEB + 4);
      chk("t3_state_stop", 8'(state), 8'd2);
      chk("t3_no_lap_we", 8'(cnt_lapwe - c0), 8'd0);
      steps(5);
      press(3'b001, DEB + 4);
      chk("t3_resumed", 8'(state), 8'd1);
      press(3'b001, DEB + 4);

      // 5: lap in stop clears, view in idle ignored
      c0 = cnt_clear;
      press(3'b010, DEB + 4);
      chk("t5_clear_pulses", 8'(cnt_clear - c0), 8'd1);
      chk("t5_state_idle", 8'(state), 8'd0);
      press(3'b100, DEB + 4);
      chk("t5_view_ignored", 8'(view_idx), 8'd0);
      chk("t5_view_state", 8'(state), 8'd0);

      // 2b: bouncing lap in run -> exactly one strobe for slot 1
      press(3'b001, DEB + 4);
      c0 = cnt_lapwe;
      raw_n[1] = 1'b0; step();
      raw_n[1] = 1'b1; step();
      raw_n[1] = 1'b0; step();
      raw_n[1] = 1'b1; step();
      raw_n[1] = 1'b0; steps(10);
      raw_n[1] = 1'b1; steps(DEB + 4);
      chk("t2_bounce_one_strobe", 8'(cnt_lapwe - c0), 8'd1);
      chk("t2_bounce_lap_idx", 8'(lap_idx), 8'd1);
      press(3'b010, DEB + 4);
      press(3'b001, DEB + 4);

      // 4: stop with two laps, view steps 1, 2, back to 0
      press(3'b100, DEB + 4);
      chk("t4_view1_idx", 8'(view_idx), 8'd1);
      chk("t4_view1_state", 8'(state), 8'd3);
      press(3'b100, DEB + 4);
      chk("t4_view2_idx", 8'(view_idx), 8'd2);
      chk("t4_view2_state", 8'(state), 8'd3);
      press(3'b100, DEB + 4);
      chk("t4_view3_idx", 8'(view_idx), 8'd0);
      chk("t4_view3_state", 8'(state), 8'd2);

      // 6: asynchronous reset mid-run with lap held through it
      press(3'b001, DEB + 4);
      steps(3);
      chk("t6_running", 8'(run), 8'd1);
      raw_n[1] = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("t6_async_run", 8'(run), 8'd0);
      chk("t6_async_tick", 8'(tick), 8'd0);
      chk("t6_async_lap_we", 8'(lap_we), 8'd0);
      chk("t6_async_state", 8'(state), 8'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      c0 = cnt_lapwe + cnt_clear;
      steps(12);
      chk("t6_no_spurious", 8'(cnt_lapwe + cnt_clear - c0), 8'd0);
      chk("t6_state_idle", 8'(state), 8'd0);
      raw_n[1] = 1'b1;
      steps(DEB + 4);

      // Random button activity, model-checked every cycle
      for (int n = 0; n < 1500; n++) begin
         for (int b = 0; b < 3; b++)
            if ($urandom_range(0, 19) == 0) raw_n[b] = ~raw_n[b];
         step();
      end
      raw_n = 3'b111;
      steps(DEB + 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the stopwatch/lap-memory datapath. It takes three raw push-buttons and owns the run/stop/clear state. It generates the centisecond tick, lap-capture write strobes with a slot index, and the display-slot selection. The datapath keeps only counters and lap storage; all mode decisions are made here.

Parameters:
TICK_DIV, 500000, clk cycles per tick pulse (10 ms at 50 MHz); legal range >= 2.
DEB_CYCLES, 16'd50000, cycles a synchronized button level must be stable before it is accepted; legal range >= 1.
LAPS, 4, number of lap slots (1..7).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
btn_start_n  input  1  raw start/stop button, active-low, asynchronous to clk
btn_lap_n  input  1  raw lap/clear button, active-low, asynchronous
btn_view_n  input  1  raw view button, active-low, asynchronous
run  output  1  high while the stopwatch counts
tick  output  1  1-cycle pulse every TICK_DIV cycles while running
clear  output  1  1-cycle pulse: datapath zeroes its counter and all lap slots
lap_we  output  1  1-cycle pulse: datapath copies the live count into slot lap_idx
lap_idx  output  3  target slot for lap_we (1..LAPS)
view_idx  output  3  slot to display (0 = live count)
state  output  2  FSM state, for debug and the display digit

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all outputs 0, lap_idx=0, view_idx=0, lap_cnt=0, prescaler=0, debouncers accept a "released" level.
- Per button:
  - 2-flop synchronizer, then debounce counter.
  - The accepted level changes only after DEB_CYCLES consecutive cycles of an equal synchronized level that differs from the current accepted level.
  - A glitch restarts the count.
  - The press event is a 1-cycle pulse on the accepted released->pressed transition; release produces no event.
  - Raw-to-event latency is 2 + DEB_CYCLES cycles. Outputs are registered, so they change 1 cycle after the event.
- Simultaneous events: priority is start > lap > view. Lower-priority events in the same cycle are dropped, not queued.
- State encoding: IDLE=0, RUN=1, STOP=2, VIEW=3. run=1 only in RUN.
- IDLE:
  - start -> RUN.
  - lap ignored.
  - view -> VIEW with view_idx=1 if lap_cnt>0; otherwise ignored.
- RUN:
  - start -> STOP.
  - lap when lap_cnt<LAPS: lap_we=1, lap_idx=lap_cnt+1, lap_cnt++.
  - lap when lap_cnt==LAPS: ignored, no strobe.
  - view ignored.
- STOP:
  - start -> RUN (resume).
  - lap -> clear=1, lap_cnt=0, view_idx=0, -> IDLE.
  - view -> VIEW with view_idx=1 if lap_cnt>0.
- VIEW:
  - Return state is the state VIEW was entered from (IDLE or STOP).
  - view when view_idx<lap_cnt: view_idx++.
  - view when view_idx==lap_cnt: view_idx=0, -> return state.
  - lap: view_idx=0, -> return state.
  - start ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; tick=1 in the cycle it equals TICK_DIV-1, after which it wraps to 0.
  - Holds its value outside RUN, so resume keeps the sub-tick phase.
  - Zeroed on clear.
- lap_idx holds its last value between strobes.
- The lap_we cycle may coincide with a tick; both are asserted. The datapath captures the pre-increment count.

Decomposition:
- Package stopwatch_pkg: state encoding constants, event priority order, default TICK_DIV and DEB_CYCLES.
- One sub-module btn_debounce (synchronizer, debounce counter, press pulse), instantiated three times.
- FSM, lap counter and prescaler live in stopwatch_ctrl.

Test Plan (TICK_DIV=4, DEB_CYCLES=3, LAPS=4):
1. Reset release, start pressed held 10 cycles -> run=1 at cycle 6 after press (2+3+1). tick every 4 cycles thereafter. state=1.
2. RUN, raw lap bounce 1-0-1-0 then held -> exactly one lap_we, lap_idx=1. Five clean lap presses -> lap_we x4 with lap_idx 1,2,3,4; fifth press gives no strobe.
3. RUN, start and lap pressed on the same clock -> STOP entered, no lap_we. Prescaler value held; after resume the first tick comes after the remaining TICK_DIV-phase cycles.
4. STOP with lap_cnt=2: view, view, view -> view_idx 1, 2, 0; state 3, 3, 2.
5. STOP, lap -> clear pulse 1 cycle, state=IDLE, lap_cnt=0. Then view in IDLE -> ignored (view_idx=0).
6. reset asserted mid-RUN between clock edges -> run, tick, lap_we fall immediately (asynchronously). After release, state=IDLE and a held button produces no spurious event.
